// File: rtl/cs_wait_pkg.sv
`default_nettype none
// cs_wait_pkg - shared state type and sizes for the chip-select wait-state generator; rev 1.0
package cs_wait_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int REGION_W    = 2;
   localparam int NUM_REGIONS = 4;
   localparam int STAT_W      = 16;

endpackage
`default_nettype wire

// File: rtl/cs_prio_enc.sv
`default_nettype none
// cs_prio_enc - lowest-index priority encoder over active-low chip selects; rev 1.0
module cs_prio_enc
   import cs_wait_pkg::*;
(
   input  logic [NUM_REGIONS-1:0] cs_n_i,
   output logic [REGION_W-1:0]    idx_o,
   output logic                   any_sel_o,
   output logic                   multi_sel_o
);

   logic [NUM_REGIONS-1:0] sel;

   always_comb begin
      sel   = ~cs_n_i;
      idx_o = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (sel[i]) idx_o = REGION_W'(i);
      end
      any_sel_o   = |sel;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_sel_o = (sel & (sel - NUM_REGIONS'(1))) != '0;
   end

endmodule
`default_nettype wire

// File: rtl/cs_wait_state_gen.sv
`default_nettype none
// cs_wait_state_gen - per-region Z80 WAIT_n generator with access strobes; rev 1.0
// Define CS_WAIT_STATS_EN to add acc_count: four 16-bit saturating per-region access counters.
module cs_wait_state_gen
   import cs_wait_pkg::*;
#(
   parameter int unsigned WAIT0 = 1,
   parameter int unsigned WAIT1 = 1,
   parameter int unsigned WAIT2 = 2,
   parameter int unsigned WAIT3 = 3,
   parameter int unsigned CNT_W = 3
) (
   input  logic                             clk,
   input  logic                             RESETn,
   input  logic                             cen,
   input  logic                             MREQ_n,
   input  logic                             RD_n,
   input  logic                             WR_n,
   input  logic [NUM_REGIONS-1:0]           CS_n,
   output logic                             WAIT_n,
   output logic [REGION_W-1:0]              region,
   output logic                             rd_start,
   output logic                             wr_start,
   output logic                             busy,
   output logic                             cs_conflict
`ifdef CS_WAIT_STATS_EN
   ,
   output logic [NUM_REGIONS*STAT_W-1:0]    acc_count
`endif
);

   localparam int unsigned MAX_WAIT = (1 << CNT_W) - 1;

   if (WAIT0 > MAX_WAIT || WAIT1 > MAX_WAIT || WAIT2 > MAX_WAIT || WAIT3 > MAX_WAIT) begin : g_wait_range_check
      $error("cs_wait_state_gen: a WAITx parameter exceeds 2**CNT_W-1");
   end

   logic [REGION_W-1:0] sel_idx;
   logic                sel_any;
   logic                sel_multi;

   cs_prio_enc u_prio_enc (
      .cs_n_i      (CS_n),
      .idx_o       (sel_idx),
      .any_sel_o   (sel_any),
      .multi_sel_o (sel_multi)
   );

   logic [CNT_W-1:0] sel_wait;

   always_comb begin
      sel_wait = CNT_W'(WAIT0);
      case (sel_idx)
         2'd1:    sel_wait = CNT_W'(WAIT1);
         2'd2:    sel_wait = CNT_W'(WAIT2);
         2'd3:    sel_wait = CNT_W'(WAIT3);
         default: sel_wait = CNT_W'(WAIT0);
      endcase
   end

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                wait_n_q;
   logic [REGION_W-1:0] region_q;
   logic                rd_q;
   logic                wr_q;
   logic                busy_q;
   logic                conf_q;
   logic                start;

   assign start = cen && (state_q == IDLE) && !MREQ_n && (!RD_n || !WR_n) && sel_any;

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wait_n_q <= 1'b1;
         region_q <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         conf_q   <= 1'b0;
      end else begin
         // Strobes live for one clk regardless of cen.
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         conf_q <= 1'b0;
         if (cen) begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     region_q <= sel_idx;
                     rd_q     <= !RD_n;
                     wr_q     <= RD_n && !WR_n;
                     conf_q   <= sel_multi;
                     busy_q   <= 1'b1;
                     if (sel_wait != '0) begin
                        cnt_q    <= sel_wait;
                        wait_n_q <= 1'b0;
                        state_q  <= WAIT;
                     end else begin
                        state_q  <= HOLD;
                     end
                  end
               end
               WAIT: begin
                  if (cnt_q == CNT_W'(1)) begin
                     cnt_q    <= '0;
                     wait_n_q <= 1'b1;
                     state_q  <= HOLD;
                  end else begin
                     cnt_q    <= cnt_q - CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (MREQ_n) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign WAIT_n      = wait_n_q;
   assign region      = region_q;
   assign rd_start    = rd_q;
   assign wr_start    = wr_q;
   assign busy        = busy_q;
   assign cs_conflict = conf_q;

`ifdef CS_WAIT_STATS_EN
   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_stats
      logic [STAT_W-1:0] acc_q;
      logic [STAT_W-1:0] acc_d;

      always_comb begin
         acc_d = acc_q;
         if (start && (sel_idx == REGION_W'(g)) && (acc_q != '1)) acc_d = acc_q + STAT_W'(1);
      end

      always_ff @(posedge clk or negedge RESETn) begin
         if (!RESETn) acc_q <= '0;
         else         acc_q <= acc_d;
      end

      assign acc_count[g*STAT_W +: STAT_W] = acc_q;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cs_wait_state_gen.sv
`default_nettype none
// tb_cs_wait_state_gen - randomized scoreboard bench for cs_wait_state_gen; rev 1.0
// Also checks acc_count when built with CS_WAIT_STATS_EN.
module tb_cs_wait_state_gen;

   localparam int W0 = 0;
   localparam int W1 = 1;
   localparam int W2 = 2;
   localparam int W3 = 3;

   logic       clk = 1'b0;
   logic       RESETn, cen, MREQ_n, RD_n, WR_n;
   logic [3:0] CS_n;
   logic       WAIT_n;
   logic [1:0] region;
   logic       rd_start, wr_start, busy, cs_conflict;
`ifdef CS_WAIT_STATS_EN
   logic [63:0] acc_count;
`endif

   cs_wait_state_gen #(
      .WAIT0(W0), .WAIT1(W1), .WAIT2(W2), .WAIT3(W3), .CNT_W(3)
   ) dut (
      .clk         (clk),
      .RESETn      (RESETn),
      .cen         (cen),
      .MREQ_n      (MREQ_n),
      .RD_n        (RD_n),
      .WR_n        (WR_n),
      .CS_n        (CS_n),
      .WAIT_n      (WAIT_n),
      .region      (region),
      .rd_start    (rd_start),
      .wr_start    (wr_start),
      .busy        (busy),
      .cs_conflict (cs_conflict)
`ifdef CS_WAIT_STATS_EN
      ,
      .acc_count   (acc_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int region;
      int rd;
      int wr;
      int conflict;
      int waits;
      int busy_ticks;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;
   int   cen_div  = 1;
   int   cyc      = 0;
   int   acc_model[4] = '{0, 0, 0, 0};
   bit   active    = 1'b0;
   bit   prev_busy = 1'b0;
   int   wcnt = 0;
   int   bcnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int region_wait(input int r);
      case (r)
         0:       return W0;
         1:       return W1;
         2:       return W2;
         default: return W3;
      endcase
   endfunction

   // Expected outcome of one access; hold_low = cen ticks after acceptance with MREQ_n still low.
   function automatic exp_t model(input logic [3:0] cs, input logic rdn, input logic wrn, input int hold_low);
      exp_t e;
      e.region = 0;
      for (int i = 3; i >= 0; i--) if (cs[i] == 1'b0) e.region = i;
      e.rd         = (rdn == 1'b0) ? 1 : 0;
      e.wr         = (rdn == 1'b1 && wrn == 1'b0) ? 1 : 0;
      e.conflict   = ($countones(~cs) >= 2) ? 1 : 0;
      e.waits      = region_wait(e.region);
      e.busy_ticks = ((e.waits > hold_low) ? e.waits : hold_low) + 1;
      return e;
   endfunction

   task automatic step(output bit t);
      @(posedge clk);
      t = (cen === 1'b1) && (RESETn === 1'b1);
      #1;
      cyc++;
      if (cen_div == 0) cen = ($urandom_range(0, 1) == 1);
      else              cen = ((cyc % cen_div) == 0);
   endtask

   task automatic go_idle();
      MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; CS_n = 4'hF;
   endtask

   task automatic do_access(input logic [3:0] cs, input logic rdn, input logic wrn, input int hold_low);
      exp_t e;
      bit   t;
      int   j;
      e = model(cs, rdn, wrn, hold_low);
      MREQ_n = 1'b0; RD_n = rdn; WR_n = wrn; CS_n = cs;
      t = 1'b0;
      while (!t) step(t);
      q.push_back(e);
      acc_model[e.region]++;
      j = 1;
      while (j <= e.busy_ticks) begin
         if (j <= hold_low) begin
            MREQ_n = 1'b0;
            if (j > e.waits + 1 && $urandom_range(0, 1) == 1) begin
               RD_n = ($urandom_range(0, 1) == 1);
               WR_n = ($urandom_range(0, 1) == 1);
            end
         end else begin
            MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) CS_n = 4'($urandom);
         step(t);
         if (t) j++;
      end
      go_idle();
   endtask

   // Bus patterns that must never be accepted.
   task automatic idle_noise(input int n);
      bit t;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0:       begin MREQ_n = 1'b0; RD_n = 1'b1; WR_n = 1'b1; CS_n = 4'($urandom); end
            1:       begin MREQ_n = 1'b0; RD_n = 1'b0; WR_n = 1'b1; CS_n = 4'hF; end
            default: begin MREQ_n = 1'b1; RD_n = 1'b0; WR_n = 1'b0; CS_n = 4'($urandom); end
         endcase
         step(t);
      end
      go_idle();
   endtask

   always @(negedge clk) begin
      if (RESETn !== 1'b1) begin
         active    = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (rd_start || wr_start) begin
            chk("start_before_busy_fell", active, 0);
            if (q.size() == 0) begin
               chk("unexpected_start", {rd_start, wr_start}, 0);
            end else begin
               cur = q.pop_front();
               chk("region", region, cur.region);
               chk("rd_start", rd_start, cur.rd);
               chk("wr_start", wr_start, cur.wr);
               chk("cs_conflict", cs_conflict, cur.conflict);
               chk("busy_at_start", busy, 1);
               active = 1'b1;
               wcnt   = 0;
               bcnt   = 0;
            end
         end else begin
            chk("conflict_without_start", cs_conflict, 0);
         end
         if (active) begin
            chk("region_latched", region, cur.region);
            if (!WAIT_n && cen) wcnt++;
            if (busy && cen) bcnt++;
            if (prev_busy && !busy) begin
               chk("wait_ticks", wcnt, cur.waits);
               chk("busy_ticks", bcnt, cur.busy_ticks);
               active = 1'b0;
            end
         end else begin
            chk("wait_n_idle", WAIT_n, 1);
         end
         prev_busy = busy;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit         t;
      exp_t       e;
      logic [3:0] cs;
      logic       rdn, wrn;
      int         kind;

      RESETn = 1'b0; cen = 1'b0;
      go_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_WAIT_n", WAIT_n, 1);
      chk("rst_region", region, 0);
      chk("rst_rd_start", rd_start, 0);
      chk("rst_wr_start", wr_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cs_conflict", cs_conflict, 0);
`ifdef CS_WAIT_STATS_EN
      chk("rst_acc_count", acc_count, 0);
`endif
      RESETn = 1'b1;
      step(t);

      cen_div = 4; do_access(4'b1011, 1'b0, 1'b1, 4);
      cen_div = 1; do_access(4'b1110, 1'b1, 1'b0, 1);
      cen_div = 2; do_access(4'b1100, 1'b0, 1'b1, 0);

      // Reset in the middle of a region-3 wait.
      cen_div = 1;
      e = model(4'b0111, 1'b0, 1'b1, 10);
      MREQ_n = 1'b0; RD_n = 1'b0; WR_n = 1'b1; CS_n = 4'b0111;
      t = 1'b0;
      while (!t) step(t);
      q.push_back(e);
      t = 1'b0;
      while (!t) step(t);
      chk("wait_n_low_before_reset", WAIT_n, 0);
      #2 RESETn = 1'b0;
      #1;
      chk("async_rst_WAIT_n", WAIT_n, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_region", region, 0);
      for (int r = 0; r < 4; r++) acc_model[r] = 0;
      go_idle();
      step(t);
      step(t);
      RESETn = 1'b1;
      step(t);
      do_access(4'b0111, 1'b1, 1'b0, 2);

      // Long hold with RD/WR toggling (no second start), then immediate re-entry.
      cen_div = 1;
      do_access(4'b1101, 1'b0, 1'b0, 8);
      do_access(4'b1101, 1'b1, 1'b0, 0);
      do_access(4'b1101, 1'b0, 1'b1, 2);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       cen_div = 0;
            1:       cen_div = 1;
            2:       cen_div = 2;
            default: cen_div = 4;
         endcase
         idle_noise(int'($urandom_range(0, 2)));
         cs = 4'($urandom);
         if (cs == 4'hF) cs = 4'($urandom_range(0, 14));
         kind = int'($urandom_range(0, 2));
         rdn  = (kind == 1);
         wrn  = (kind == 0);
         do_access(cs, rdn, wrn, int'($urandom_range(0, 6)));
      end

      repeat (4) step(t);
      chk("queue_drained", q.size(), 0);
      chk("access_completed", active, 0);
`ifdef CS_WAIT_STATS_EN
      for (int r = 0; r < 4; r++)
         chk($sformatf("acc_count_r%0d", r), acc_count[16*r +: 16],
             (acc_model[r] > 65535) ? 65535 : acc_model[r]);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
